serial_sub: RTL and testbench

- Bit-serial unsigned/two's-complement subtractor computing diff = a - b, one bit per clock, LSB first, with a registered borrow flip-flop.
- It is the inverse operation to the half/full adder cells in the arithmetic section of the codebase.
- It sits next to the serial adder datapath as the subtraction unit, driven by a start/done handshake from a control FSM.

---
 rtl/serial_sub.sv | 121 ++++++++++++
 tb/tb_serial_sub.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor diff = a - b, LSB first, with a registered borrow.
// Optional signed-overflow output ovf is enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d, rb_q, rb_d, res_q, res_d, diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d, borrow_q, borrow_d, busy_q, busy_d, done_q, done_d;
    logic             a0, b0, d_bit, br_nx, last;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Next-state: load on accepted start, one full-subtractor step per RUN cycle, publish on DONE entry
    always_comb begin
        a0       = ra_q[0];
        b0       = rb_q[0];
        d_bit    = a0 ^ b0 ^ br_q;
        br_nx    = (~a0 & b0) | (~(a0 ^ b0) & br_q);
        last     = cnt_q == CW'(WIDTH - 1);
        state_d  = state_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                ra_d    = a;
                rb_d    = b;
                br_d    = 1'b0;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                res_d = {d_bit, res_q[WIDTH-1:1]};
                ra_d  = ra_q >> 1;
                rb_d  = rb_q >> 1;
                br_d  = br_nx;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    state_d  = DONE;
                    diff_d   = {d_bit, res_q[WIDTH-1:1]};
                    borrow_d = br_nx;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d    = (a0 != b0) && (d_bit != a0);
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = state_d == RUN;
        done_d = state_d == DONE;
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ra_q     <= '0;
            rb_q     <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf    = ovf_q;
`endif
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: directed scoreboard bench for serial_sub (WIDTH=8), ovf checked when SERIAL_SUB_OVF_EN is defined.
module tb_serial_sub;
    logic       clk = 1'b0;
    logic       reset, start;
    logic [7:0] a, b, diff;
    logic       busy, done, borrow, ovf;
    int         total = 0, bad = 0, cyc = 0, last_issue = 0;

    typedef struct {
        logic [7:0] d;
        logic       br;
        logic       ov;
    } exp_t;
    exp_t exp_q[$];

    serial_sub #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow(borrow)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf)
`endif
    );

`ifndef SERIAL_SUB_OVF_EN
    assign ovf = 1'b0;
`endif

    always #5 clk = ~clk;

    // Count rising edges so acceptance spacing can be measured
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y);
        exp_t r;
        r.d  = x - y;
        r.br = x < y;
        r.ov = (x[7] != y[7]) && (r.d[7] != x[7]);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 0, 1);
            return;
        end
        e = exp_q.pop_front();
        check({tag, "_diff"}, diff, e.d);
        check({tag, "_borrow"}, borrow, e.br);
`ifdef SERIAL_SUB_OVF_EN
        check({tag, "_ovf"}, ovf, e.ov);
`endif
    endtask

    // Drive start for one cycle at a negedge; returns at the negedge after acceptance
    task automatic issue(input logic [7:0] x, input logic [7:0] y);
        a = x;
        b = y;
        start = 1'b1;
        last_issue = cyc;
        exp_q.push_back(model(x, y));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts busy cycles until done, checks result, then checks done is a single-cycle pulse
    task automatic wait_done(input string tag, input int exp_busy);
        int n = 0, nb = 0;
        while (!done && n < 40) begin
            if (busy) nb++;
            n++;
            @(negedge clk);
        end
        check({tag, "_timeout"}, n < 40, 1);
        if (done) begin
            check({tag, "_busycnt"}, nb, exp_busy);
            check({tag, "_busy_at_done"}, busy, 0);
            check_result(tag);
            @(negedge clk);
            check({tag, "_done_pulse"}, done, 0);
        end
    endtask

    initial begin
        int prev, ndone, last_done;
        logic pd;
        reset = 1'b1;
        start = 1'b1;
        a = 8'h5A;
        b = 8'h23;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow, 0);
        check("rst_ovf", ovf, 0);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);

        issue(8'h5A, 8'h23);
        check("op1_busy", busy, 1);
        wait_done("op1", 8);
        check("hold_diff", diff, 8'h37);

        issue(8'h00, 8'h01);
        wait_done("op2", 8);
        issue(8'h80, 8'h01);
        wait_done("op3", 8);
        issue(8'h7F, 8'hFF);
        wait_done("op4", 8);

        issue(8'h80, 8'h80);
        wait_done("op5", 8);
        prev = last_issue;
        issue(8'h01, 8'h02);
        check("b2b_interval", last_issue - prev, 10);
        wait_done("op6", 8);

        issue(8'h10, 8'h01);
        @(negedge clk);
        start = 1'b1;
        a = 8'hFF;
        b = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        wait_done("ign", 6);
        repeat (5) @(negedge clk);
        check("ign_no_queue", busy, 0);
        check("ign_diff_held", diff, 8'h0F);

        issue(8'h10, 8'h01);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        void'(exp_q.pop_back());
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_diff", diff, 0);
        check("abort_borrow", borrow, 0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("abort_quiet", ndone, 0);

        a = 8'h03;
        b = 8'h05;
        start = 1'b1;
        repeat (3) exp_q.push_back(model(8'h03, 8'h05));
        ndone = 0;
        pd = 1'b0;
        last_done = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done) begin
                check("hold_no_consec", pd, 0);
                check_result("hold");
                if (last_done >= 0) check("hold_period", cyc - last_done, 10);
                last_done = cyc;
                ndone++;
            end
            pd = done;
        end
        start = 1'b0;
        check("hold_count", ndone, 3);
        repeat (3) @(negedge clk);
        check("hold_idle", busy, 0);
        check("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
